// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp_if
// Brief    : Read/write/reserve bus between a requester and register_file_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic [ADDR_W-1:0] w;
    logic [DATA_W-1:0] data_in;
    logic              we;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [DATA_W-1:0] data_out1;
    logic [DATA_W-1:0] data_out2;
    logic              busy1;
    logic              busy2;
    logic              ready;

    modport master (
        output r1, r2, w, data_in, we, rsv_en, rsv_addr,
        input  data_out1, data_out2, busy1, busy2, ready
    );

    modport slave (
        input  r1, r2, w, data_in, we, rsv_en, rsv_addr,
        output data_out1, data_out2, busy1, busy2, ready
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Brief    : 2-read/1-write register file with busy (reservation) tracking,
//            optional write bypass and a hardwired zero register.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    register_file_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_d;

    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]    busy_q;

    logic [ADDR_W-1:0]   rd_addr   [2];
    logic [DATA_W-1:0]   rd_data_q [2];
    logic [DATA_W-1:0]   rd_data_d [2];
    logic                rd_busy_q [2];
    logic                rd_busy_d [2];

    logic                w_wr_ok;
    logic                w_rsv_ok;
    logic                w_wr_busy_post;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes and reserves only take effect once clearing is done and never
    // touch the hardwired zero register.
    assign w_wr_ok        = (state_q == READY) && bus.we     && !is_zero(bus.w);
    assign w_rsv_ok       = (state_q == READY) && bus.rsv_en && !is_zero(bus.rsv_addr);
    assign w_wr_busy_post = w_rsv_ok && (bus.rsv_addr == bus.w);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (&clr_cnt_q) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read ports: forwarded write data sees the busy value after the edge.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_addr[0] = bus.r1;
        rd_addr[1] = bus.r2;
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p] = '0;
            rd_busy_d[p] = 1'b0;
            if ((state_q == READY) && !is_zero(rd_addr[p])) begin
                if ((BYPASS != 0) && w_wr_ok && (rd_addr[p] == bus.w)) begin
                    rd_data_d[p] = bus.data_in;
                    rd_busy_d[p] = w_wr_busy_post;
                end else begin
                    rd_data_d[p] = regs_q[rd_addr[p]];
                    rd_busy_d[p] = busy_q[rd_addr[p]];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rd_data_q[p] <= '0;
                rd_busy_q[p] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            for (int p = 0; p < 2; p++) begin
                rd_data_q[p] <= rd_data_d[p];
                rd_busy_q[p] <= rd_busy_d[p];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: contents are defined only by the clear sweep; a reserve on the
    // same edge as a write to the same entry leaves it busy.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                regs_q[clr_cnt_q] <= '0;
                busy_q[clr_cnt_q] <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    regs_q[bus.w] <= bus.data_in;
                    busy_q[bus.w] <= 1'b0;
                end
                if (w_rsv_ok) begin
                    busy_q[bus.rsv_addr] <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out1 = rd_data_q[0];
    assign bus.data_out2 = rd_data_q[1];
    assign bus.busy1     = rd_busy_q[0];
    assign bus.busy2     = rd_busy_q[1];
    assign bus.ready     = (state_q == READY);

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Brief    : Directed and random stimulus for register_file_mp against a
//            behavioural array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: whole-array wipe on reset, ready after DEPTH clean edges.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_bsy [DEPTH];
    int                m_edges = 0;
    bit                m_rdy   = 1'b0;
    logic [DATA_W-1:0] e_d1, e_d2;
    bit                e_b1, e_b2;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_read(input logic [ADDR_W-1:0] a, input bit wr,
                                   input bit post_busy,
                                   output logic [DATA_W-1:0] d, output bit b);
        if (a == '0) begin
            d = '0;
            b = 1'b0;
        end else if (wr && a == bus.w) begin
            d = bus.data_in;
            b = post_busy;
        end else begin
            d = m_mem[a];
            b = m_bsy[a];
        end
    endfunction

    task automatic model_edge();
        bit wr, rs, post;
        if (reset) begin
            m_edges = 0;
            m_rdy   = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_bsy[i] = 1'b0;
            end
            e_d1 = '0; e_d2 = '0; e_b1 = 1'b0; e_b2 = 1'b0;
        end else if (!m_rdy) begin
            m_edges++;
            m_rdy = (m_edges >= DEPTH);
            e_d1 = '0; e_d2 = '0; e_b1 = 1'b0; e_b2 = 1'b0;
        end else begin
            wr   = bus.we && (bus.w != '0);
            rs   = bus.rsv_en && (bus.rsv_addr != '0);
            post = rs && (bus.rsv_addr == bus.w);
            m_read(bus.r1, wr, post, e_d1, e_b1);
            m_read(bus.r2, wr, post, e_d2, e_b2);
            if (wr) begin
                m_mem[bus.w] = bus.data_in;
                m_bsy[bus.w] = 1'b0;
            end
            if (rs) m_bsy[bus.rsv_addr] = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ready"}, {31'b0, bus.ready}, {31'b0, m_rdy});
        check({tag, ".d1"},    bus.data_out1,      e_d1);
        check({tag, ".d2"},    bus.data_out2,      e_d2);
        check({tag, ".b1"},    {31'b0, bus.busy1}, {31'b0, e_b1});
        check({tag, ".b2"},    {31'b0, bus.busy2}, {31'b0, e_b2});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        bus.we     = 1'b0;
        bus.rsv_en = 1'b0;
        bus.w      = '0;
        bus.data_in = '0;
        bus.rsv_addr = '0;
    endtask

    task automatic rand_addr(output logic [ADDR_W-1:0] a);
        if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, DEPTH - 1));
        else                           a = ADDR_W'($urandom_range(0, 7));
    endtask

    // Release reset and walk the clear sweep, pinning the ready edge.
    task automatic clear_sweep(input string tag);
        reset = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            step(tag);
            if (i == DEPTH - 1) check({tag, ".ready_low"},  {31'b0, bus.ready}, 32'd0);
            if (i == DEPTH)     check({tag, ".ready_high"}, {31'b0, bus.ready}, 32'd1);
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            bus.r1 = ADDR_W'(i);
            bus.r2 = ADDR_W'(DEPTH - 1 - i);
            step(tag);
            check({tag, ".zero_d1"}, bus.data_out1, 32'd0);
            check({tag, ".zero_b2"}, {31'b0, bus.busy2}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.r1 = '0;
        bus.r2 = '0;
        idle();

        // Single-cycle reset, full clear sweep, everything reads zero.
        step("rst");
        check("rst.ready", {31'b0, bus.ready}, 32'd0);
        clear_sweep("clr");
        read_all_zero("init");

        // Write then read on the following cycle.
        bus.we = 1'b1; bus.w = 5'd5; bus.data_in = 32'h1234_5678; bus.r1 = 5'd1;
        step("wr5");
        idle(); bus.r1 = 5'd5;
        step("rd5");
        check("rd5.lit", bus.data_out1, 32'h1234_5678);

        // Same-cycle write forwarded to port 2.
        bus.we = 1'b1; bus.w = 5'd7; bus.data_in = 32'hDEAD_BEEF; bus.r2 = 5'd7;
        step("byp7");
        check("byp7.lit", bus.data_out2, 32'hDEAD_BEEF);
        idle();

        // Zero register ignores writes, reserves and bypass.
        bus.we = 1'b1; bus.w = 5'd0; bus.data_in = 32'hFFFF_FFFF;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; bus.r1 = 5'd0; bus.r2 = 5'd0;
        step("wr0");
        check("wr0.byp", bus.data_out1, 32'd0);
        idle();
        step("rd0");
        check("rd0.d1", bus.data_out1, 32'd0);
        check("rd0.b1", {31'b0, bus.busy1}, 32'd0);

        // Reserve / write / reserve-wins sequence on r3.
        bus.r1 = 5'd3; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        step("rsv3");
        idle();
        step("rsv3.rd");
        check("rsv3.b1", {31'b0, bus.busy1}, 32'd1);
        bus.we = 1'b1; bus.w = 5'd3; bus.data_in = 32'h55;
        step("wr3");
        idle();
        step("wr3.rd");
        check("wr3.d1", bus.data_out1, 32'h55);
        check("wr3.b1", {31'b0, bus.busy1}, 32'd0);
        bus.we = 1'b1; bus.w = 5'd3; bus.data_in = 32'h66;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        step("both3");
        idle();
        step("both3.rd");
        check("both3.d1", bus.data_out1, 32'h66);
        check("both3.b1", {31'b0, bus.busy1}, 32'd1);

        // Random traffic with collisions and rare resets.
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a;
            reset       = ($urandom_range(0, 149) == 0);
            bus.we      = $urandom_range(0, 1) == 1;
            bus.rsv_en  = $urandom_range(0, 2) == 0;
            bus.data_in = $urandom;
            rand_addr(a); bus.w        = a;
            rand_addr(a); bus.rsv_addr = a;
            rand_addr(a); bus.r1       = a;
            if ($urandom_range(0, 4) == 0) bus.r2 = bus.r1;
            else begin rand_addr(a); bus.r2 = a; end
            step("rnd");
        end
        idle();

        // Reset in the middle of a clear sweep.
        reset = 1'b1;
        step("mid.rst");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step("mid.pre");
        reset = 1'b1;
        step("mid.rst2");
        clear_sweep("mid");

        // Reset in READY after writes.
        for (int i = 1; i < 8; i++) begin
            bus.we = 1'b1; bus.w = ADDR_W'(i); bus.data_in = $urandom;
            bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(i + 8);
            step("pre.wr");
        end
        idle();
        reset = 1'b1;
        step("rdy.rst");
        check("rdy.rst.d1", bus.data_out1, 32'd0);
        clear_sweep("rdy");
        read_all_zero("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
